// File: rtl/pdu_outbuf_pkg.sv
// Shared constants and types for the PDU output buffer.
package pdu_outbuf_pkg;

  localparam int unsigned NUM_PCH   = 8;
  localparam int unsigned OPCODE_BW = 5;
  localparam int unsigned LQADDR_BW = 3;

  localparam logic [OPCODE_BW-1:0] INVALID_OPCODE = '1;
  localparam logic [1:0]           PP_I           = 2'b00;

  localparam int unsigned BUNDLE_W =
      OPCODE_BW + NUM_PCH + 2 * NUM_PCH * (2 + OPCODE_BW + LQADDR_BW) + 1;

  typedef enum logic {
    PH0 = 1'b0,
    PH1 = 1'b1
  } phase_e;

  typedef struct packed {
    logic                           need1;
    logic [OPCODE_BW-1:0]           opcode;
    logic [NUM_PCH-1:0]             pch_list;
    logic [NUM_PCH*2-1:0]           pp0;
    logic [NUM_PCH*OPCODE_BW-1:0]   op0;
    logic [NUM_PCH*LQADDR_BW-1:0]   mreg0;
    logic [NUM_PCH*2-1:0]           pp1;
    logic [NUM_PCH*OPCODE_BW-1:0]   op1;
    logic [NUM_PCH*LQADDR_BW-1:0]   mreg1;
  } bundle_t;

  // True when any per-patch opcode in the list is a real operation.
  function automatic logic any_valid_op(input logic [NUM_PCH*OPCODE_BW-1:0] ops);
    logic any;
    any = 1'b0;
    for (int i = 0; i < int'(NUM_PCH); i++) begin
      if (ops[i*OPCODE_BW +: OPCODE_BW] != INVALID_OPCODE) any = 1'b1;
    end
    return any;
  endfunction

endpackage

// File: rtl/pdu_outbuf_fifo.sv
// Generic synchronous FIFO; caller guarantees no push when full and no pop when empty.
module pdu_outbuf_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; the top masks data whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/pdu_outbuf.sv
// Elastic buffer after the PDU: stores bundles and emits them as one or two beats.
// Optional statistics counters are built when PDU_OUTBUF_STATS_EN is defined.
module pdu_outbuf
  import pdu_outbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pduout_valid,
  input  logic [OPCODE_BW-1:0]            pduout_opcode,
  input  logic [NUM_PCH-1:0]              pch_list,
  input  logic [NUM_PCH*2-1:0]            pchpp_list0,
  input  logic [NUM_PCH*2-1:0]            pchpp_list1,
  input  logic [NUM_PCH*OPCODE_BW-1:0]    pchop_list0,
  input  logic [NUM_PCH*OPCODE_BW-1:0]    pchop_list1,
  input  logic [NUM_PCH*LQADDR_BW-1:0]    pchmreg_list0,
  input  logic [NUM_PCH*LQADDR_BW-1:0]    pchmreg_list1,
  output logic                            pdu_stall,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_phase,
  output logic                            out_last,
  output logic [OPCODE_BW-1:0]            out_opcode,
  output logic [NUM_PCH-1:0]              out_pch_list,
  output logic [NUM_PCH*2-1:0]            out_pchpp,
  output logic [NUM_PCH*OPCODE_BW-1:0]    out_pchop,
  output logic [NUM_PCH*LQADDR_BW-1:0]    out_pchmreg,
  output logic [15:0]                     stat_bundles,
  output logic [15:0]                     stat_beats,
  output logic [15:0]                     stat_stall_cyc
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  bundle_t         wr_bundle;
  bundle_t         head;
  logic [CntW-1:0] count;
  logic            push, pop, hs;
  phase_e          phase_q, phase_d;

  always_comb begin
    wr_bundle          = '0;
    wr_bundle.need1    = any_valid_op(pchop_list1);
    wr_bundle.opcode   = pduout_opcode;
    wr_bundle.pch_list = pch_list;
    wr_bundle.pp0      = pchpp_list0;
    wr_bundle.op0      = pchop_list0;
    wr_bundle.mreg0    = pchmreg_list0;
    wr_bundle.pp1      = pchpp_list1;
    wr_bundle.op1      = pchop_list1;
    wr_bundle.mreg1    = pchmreg_list1;
  end

  pdu_outbuf_fifo #(
    .WIDTH (BUNDLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_bundle),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  // Stall depends only on registered occupancy, never on out_ready.
  assign pdu_stall = (count == CntW'(DEPTH));
  assign push      = pduout_valid & ~pdu_stall;
  assign out_valid = (count != '0);
  assign hs        = out_valid & out_ready;
  assign pop       = hs & ((phase_q == PH1) | ~head.need1);
  assign out_phase = phase_q;

  always_comb begin
    phase_d = phase_q;
    if (hs) begin
      unique case (phase_q)
        PH0:     phase_d = head.need1 ? PH1 : PH0;
        PH1:     phase_d = PH0;
        default: phase_d = PH0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= PH0;
    else     phase_q <= phase_d;
  end

  // Idle values are presented whenever the buffer is empty.
  always_comb begin
    out_last     = 1'b0;
    out_opcode   = '0;
    out_pch_list = '0;
    out_pchpp    = {NUM_PCH{PP_I}};
    out_pchop    = {NUM_PCH{INVALID_OPCODE}};
    out_pchmreg  = '0;
    if (out_valid) begin
      out_last     = (phase_q == PH1) | ~head.need1;
      out_opcode   = head.opcode;
      out_pch_list = head.pch_list;
      if (phase_q == PH1) begin
        out_pchpp   = head.pp1;
        out_pchop   = head.op1;
        out_pchmreg = head.mreg1;
      end else begin
        out_pchpp   = head.pp0;
        out_pchop   = head.op0;
        out_pchmreg = head.mreg0;
      end
    end
  end

`ifdef PDU_OUTBUF_STATS_EN
  logic [15:0] bundles_q, bundles_d;
  logic [15:0] beats_q, beats_d;
  logic [15:0] stall_cyc_q, stall_cyc_d;

  always_comb begin
    bundles_d   = bundles_q;
    beats_d     = beats_q;
    stall_cyc_d = stall_cyc_q;
    if (push && bundles_q != 16'hFFFF) bundles_d = bundles_q + 16'd1;
    if (hs && beats_q != 16'hFFFF) beats_d = beats_q + 16'd1;
    if (pduout_valid && pdu_stall && stall_cyc_q != 16'hFFFF) stall_cyc_d = stall_cyc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundles_q   <= '0;
      beats_q     <= '0;
      stall_cyc_q <= '0;
    end else begin
      bundles_q   <= bundles_d;
      beats_q     <= beats_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign stat_bundles   = bundles_q;
  assign stat_beats     = beats_q;
  assign stat_stall_cyc = stall_cyc_q;
`else
  assign stat_bundles   = 16'd0;
  assign stat_beats     = 16'd0;
  assign stat_stall_cyc = 16'd0;
`endif

endmodule

// File: tb/tb_pdu_outbuf.sv
// Randomised scoreboard bench for pdu_outbuf: a queue of expected beats is checked every cycle.
module tb_pdu_outbuf;
  import pdu_outbuf_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OPW   = NUM_PCH * OPCODE_BW;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          pduout_valid;
  logic [OPCODE_BW-1:0]          pduout_opcode;
  logic [NUM_PCH-1:0]            pch_list;
  logic [NUM_PCH*2-1:0]          pchpp_list0, pchpp_list1;
  logic [OPW-1:0]                pchop_list0, pchop_list1;
  logic [NUM_PCH*LQADDR_BW-1:0]  pchmreg_list0, pchmreg_list1;
  logic                          pdu_stall, out_valid, out_ready, out_phase, out_last;
  logic [OPCODE_BW-1:0]          out_opcode;
  logic [NUM_PCH-1:0]            out_pch_list;
  logic [NUM_PCH*2-1:0]          out_pchpp;
  logic [OPW-1:0]                out_pchop;
  logic [NUM_PCH*LQADDR_BW-1:0]  out_pchmreg;
  logic [15:0]                   stat_bundles, stat_beats, stat_stall_cyc;

  pdu_outbuf #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pduout_valid   (pduout_valid),
    .pduout_opcode  (pduout_opcode),
    .pch_list       (pch_list),
    .pchpp_list0    (pchpp_list0),
    .pchpp_list1    (pchpp_list1),
    .pchop_list0    (pchop_list0),
    .pchop_list1    (pchop_list1),
    .pchmreg_list0  (pchmreg_list0),
    .pchmreg_list1  (pchmreg_list1),
    .pdu_stall      (pdu_stall),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_phase      (out_phase),
    .out_last       (out_last),
    .out_opcode     (out_opcode),
    .out_pch_list   (out_pch_list),
    .out_pchpp      (out_pchpp),
    .out_pchop      (out_pchop),
    .out_pchmreg    (out_pchmreg),
    .stat_bundles   (stat_bundles),
    .stat_beats     (stat_beats),
    .stat_stall_cyc (stat_stall_cyc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                         ph;
    logic                         last;
    logic [OPCODE_BW-1:0]         opc;
    logic [NUM_PCH-1:0]           pl;
    logic [NUM_PCH*2-1:0]         pp;
    logic [OPW-1:0]               op;
    logic [NUM_PCH*LQADDR_BW-1:0] mr;
  } beat_t;

  beat_t q[$];
  int    nb_model;      // bundles held: one per queued beat marked last
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  bit    accepted = 1'b0;
  bit    saw_ph1 = 1'b0;
  logic [15:0] m_bundles = 0, m_beats = 0, m_stall = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  // Monitor compares DUT against the head of the expected-beat queue, then
  // advances the model by what the coming clock edge will do.
  always @(negedge clk) begin
    if (mon_en) begin
      bit full;
      chk("pdu_stall", 64'(pdu_stall), 64'(nb_model == int'(DEPTH)));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_phase", 64'(out_phase), 64'(q[0].ph));
        chk("out_last", 64'(out_last), 64'(q[0].last));
        chk("out_opcode", 64'(out_opcode), 64'(q[0].opc));
        chk("out_pch_list", 64'(out_pch_list), 64'(q[0].pl));
        chk("out_pchpp", 64'(out_pchpp), 64'(q[0].pp));
        chk("out_pchop", 64'(out_pchop), 64'(q[0].op));
        chk("out_pchmreg", 64'(out_pchmreg), 64'(q[0].mr));
        if (q[0].ph) saw_ph1 = 1'b1;
      end else begin
        chk("idle_pchop", 64'(out_pchop), {64{1'b1}} >> (64 - OPW));
        chk("idle_fields", 64'({out_phase, out_last, out_opcode, out_pch_list, out_pchpp,
                                out_pchmreg}), 64'd0);
      end
`ifdef PDU_OUTBUF_STATS_EN
      chk("stat_bundles", 64'(stat_bundles), 64'(m_bundles));
      chk("stat_beats", 64'(stat_beats), 64'(m_beats));
      chk("stat_stall_cyc", 64'(stat_stall_cyc), 64'(m_stall));
`else
      chk("stats_off", 64'({stat_bundles, stat_beats, stat_stall_cyc}), 64'd0);
`endif
      full = (nb_model == int'(DEPTH));
      accepted = 1'b0;
      if (rst) begin
        q.delete();
        nb_model = 0;
        m_bundles = 0; m_beats = 0; m_stall = 0;
      end else begin
        if (pduout_valid && full) m_stall = sat(m_stall);
        if (q.size() != 0 && out_ready) begin
          if (q[0].last) nb_model--;
          void'(q.pop_front());
          m_beats = sat(m_beats);
        end
        if (pduout_valid && !full) begin
          beat_t b;
          bit    need1;
          need1 = 1'b0;
          for (int i = 0; i < int'(NUM_PCH); i++)
            if (pchop_list1[i*OPCODE_BW +: OPCODE_BW] != 5'h1F) need1 = 1'b1;
          b = '{ph: 1'b0, last: !need1, opc: pduout_opcode, pl: pch_list,
                pp: pchpp_list0, op: pchop_list0, mr: pchmreg_list0};
          q.push_back(b);
          if (need1) begin
            b = '{ph: 1'b1, last: 1'b1, opc: pduout_opcode, pl: pch_list,
                  pp: pchpp_list1, op: pchop_list1, mr: pchmreg_list1};
            q.push_back(b);
          end
          nb_model++;
          m_bundles = sat(m_bundles);
          accepted = 1'b1;
        end
      end
    end
  end

  task automatic gen_bundle(input bit two);
    pduout_opcode = 5'($urandom_range(0, 30));
    pch_list      = 8'($urandom);
    pchpp_list0   = 16'($urandom);
    pchpp_list1   = 16'($urandom);
    pchop_list0   = {8'($urandom), $urandom};
    pchmreg_list0 = 24'($urandom);
    pchmreg_list1 = 24'($urandom);
    pchop_list1   = '1;
    if (two) begin
      for (int i = 0; i < int'(NUM_PCH); i++)
        if ($urandom_range(0, 1) == 1) pchop_list1[i*OPCODE_BW +: OPCODE_BW] = 5'($urandom_range(0, 30));
      pchop_list1[$urandom_range(0, NUM_PCH-1)*OPCODE_BW +: OPCODE_BW] = 5'($urandom_range(0, 30));
    end
  endtask

  // A bundle not yet accepted is held unchanged, as the PDU does while stalled.
  task automatic step(input bit v, input bit r, input bit rs, input int two);
    @(posedge clk);
    #1;
    rst       = rs;
    out_ready = r;
    if (!(pduout_valid && !accepted)) begin
      pduout_valid = v;
      if (v) gen_bundle(two == 2 ? bit'($urandom_range(0, 1)) : bit'(two));
    end
  endtask

  task automatic run(input int n, input int pv, input int pr, input int two);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr, 1'b0, two);
  endtask

  initial begin
    int guard;
    nb_model = 0;
    rst = 1'b1; out_ready = 1'b0; pduout_valid = 1'b0;
    gen_bundle(1'b0);
    @(posedge clk);
    #1 mon_en = 1'b1;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    // single one-beat bundle, then a two-beat bundle, both with ready high
    step(1, 1, 0, 0); repeat (3) step(0, 1, 0, 0);
    step(1, 1, 0, 1); repeat (4) step(0, 1, 0, 0);
    // fill while blocked, hold the fifth bundle, then release
    repeat (8) step(1, 0, 0, 2);
    repeat (20) step(0, 1, 0, 0);
    // full with simultaneous pop and new valid
    repeat (5) step(1, 0, 0, 0);
    repeat (6) step(1, 1, 0, 0);
    repeat (12) step(0, 1, 0, 0);
    // ready toggling during a two-beat bundle
    step(1, 1, 0, 1);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    // reset while the head sits in its list1 beat with two entries stored
    step(1, 0, 0, 1); step(1, 0, 0, 1);
    step(0, 0, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    chk("reached_ph1_before_rst", 64'(saw_ph1), 64'd1);
    repeat (3) step(0, 1, 0, 0);
    // randomised traffic
    run(300, 70, 50, 2);
    run(150, 90, 30, 2);
    run(150, 40, 90, 2);
    // drain with a bounded wait
    guard = 0;
    while ((q.size() != 0 || (pduout_valid && !accepted)) && guard < 200) begin
      step(0, 1, 0, 0);
      guard++;
    end
    chk("drain_within_bound", 64'(guard < 200), 64'd1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
